// File: rtl/v2f_seq_divmod_pkg.sv
// Shared constants for the sequential divide/modulo unit: state encodings and signal width.
package v2f_seq_divmod_pkg;

    localparam int unsigned V2F_SIGNAL_WIDTH = 32;

    localparam logic [1:0] V2F_ST_IDLE = 2'd0;
    localparam logic [1:0] V2F_ST_CALC = 2'd1;
    localparam logic [1:0] V2F_ST_DONE = 2'd2;

    // Iteration counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/v2f_seq_divmod_cond_neg.sv
// Conditional two's-complement negation: y = neg ? -a : a (wraps at WIDTH bits).
module v2f_seq_divmod_cond_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/v2f_seq_divmod.sv
// Multi-cycle restoring divider returning quotient and remainder with truncating,
// divide-by-zero-yields-zero, wrap-on-overflow semantics. Requires WIDTH >= 2.
module v2f_seq_divmod
    import v2f_seq_divmod_pkg::*;
#(
    parameter int unsigned WIDTH  = V2F_SIGNAL_WIDTH,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_zero
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   rem;
    logic [CNT_W-1:0] cnt;
    logic             s_a;
    logic             s_b;

    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic             accept_c;
    logic             dsr_zero_c;
    logic [WIDTH:0]   rem_sh_c;
    logic [WIDTH:0]   diff_c;
    logic             ge_c;
    logic [WIDTH:0]   rem_step_c;
    logic [WIDTH-1:0] quo_step_c;
    logic [WIDTH-1:0] q_fix_c;
    logic [WIDTH-1:0] r_fix_c;

    assign in_ready   = (state == V2F_ST_IDLE) && !rst;
    assign accept_c   = in_valid && in_ready;
    assign dsr_zero_c = (dsr == '0);

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    assign a_neg_c = SIGNED && A[WIDTH-1];
    assign b_neg_c = SIGNED && B[WIDTH-1];

    v2f_seq_divmod_cond_neg #(.WIDTH(WIDTH)) u_neg_a (.a(A), .neg(a_neg_c), .y(a_mag_c));
    v2f_seq_divmod_cond_neg #(.WIDTH(WIDTH)) u_neg_b (.a(B), .neg(b_neg_c), .y(b_mag_c));

    // One restoring step: the dividend register doubles as the quotient shift register.
    assign rem_sh_c   = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    assign diff_c     = rem_sh_c - {1'b0, dsr};
    assign ge_c       = ~diff_c[WIDTH];
    assign rem_step_c = ge_c ? diff_c : rem_sh_c;
    assign quo_step_c = {dvd[WIDTH-2:0], ge_c};

    // Quotient sign follows sA^sB, remainder sign follows the dividend.
    v2f_seq_divmod_cond_neg #(.WIDTH(WIDTH)) u_neg_q (.a(quo_step_c), .neg(s_a ^ s_b), .y(q_fix_c));
    v2f_seq_divmod_cond_neg #(.WIDTH(WIDTH)) u_neg_r (.a(rem_step_c[WIDTH-1:0]), .neg(s_a), .y(r_fix_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= V2F_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            V2F_ST_IDLE: if (accept_c) state_nxt = V2F_ST_CALC;
            V2F_ST_CALC: if (dsr_zero_c || (cnt == '0)) state_nxt = V2F_ST_DONE;
            V2F_ST_DONE: if (out_ready) state_nxt = V2F_ST_IDLE;
            default:     state_nxt = V2F_ST_IDLE;
        endcase
    end

    // Datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            cnt       <= '0;
            s_a       <= 1'b0;
            s_b       <= 1'b0;
            Q         <= '0;
            R         <= '0;
            div_zero  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept_c) begin
                dvd <= a_mag_c;
                dsr <= b_mag_c;
                s_a <= a_neg_c;
                s_b <= b_neg_c;
                rem <= '0;
                cnt <= CNT_W'(WIDTH - 1);
            end
            if (state == V2F_ST_CALC) begin
                if (dsr_zero_c) begin
                    Q         <= '0;
                    R         <= '0;
                    div_zero  <= 1'b1;
                    out_valid <= 1'b1;
                end else begin
                    dvd <= quo_step_c;
                    rem <= rem_step_c;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        Q         <= q_fix_c;
                        R         <= r_fix_c;
                        div_zero  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
            end
            if ((state == V2F_ST_DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_v2f_seq_divmod.sv
// Scoreboard bench for v2f_seq_divmod: signed and unsigned instances against a reference model.
module tb_v2f_seq_divmod;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, div_zero;
    logic [W-1:0] A, B, Q, R;
    logic         u_in_valid, u_in_ready, u_out_valid, u_div_zero;
    logic [W-1:0] u_A, u_B, u_Q, u_R;

    exp_t sb_q[$];
    exp_t sbu_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   last_acc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    v2f_seq_divmod #(.WIDTH(W), .SIGNED(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .R(R), .div_zero(div_zero)
    );

    v2f_seq_divmod #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready), .A(u_A), .B(u_B),
        .out_valid(u_out_valid), .out_ready(1'b1), .Q(u_Q), .R(u_R), .div_zero(u_div_zero)
    );

    // Reference: language division truncates toward zero; 64-bit math then wrap to W bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        exp_t   e;
        longint la, lb;
        if (b == '0) begin
            e.q = '0; e.r = '0; e.dz = 1'b1;
        end else if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            e.q = W'(la / lb); e.r = W'(la % lb); e.dz = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Issue one operation to the signed unit once it is ready; records the accept cycle.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
            return;
        end
        A = a; B = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        last_acc = cyc;
        sb_q.push_back(model(a, b, 1'b1));
    endtask

    // Wait (bounded) for out_valid; returns latency in edges after the accept edge.
    task automatic wait_result(output int lat, output bit ok);
        int n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        ok  = out_valid;
        lat = cyc - last_acc;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL result_timeout out_valid=%b required 1", out_valid);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
        u_in_valid = 1'b0; u_A = '0; u_B = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || Q !== '0 || R !== '0 || div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state rdy=%b ov=%b Q=%h R=%h dz=%b required 0 0 0 0 0",
                     in_ready, out_valid, Q, R, div_zero);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        int   lat; bit ok; exp_t e;
        send(a, b);
        wait_result(lat, ok);
        if (ok) begin
            e = sb_q.pop_front();
            vectors += 2;
            if (Q !== e.q || R !== e.r || div_zero !== e.dz) begin
                miscompares++;
                $display("FAIL %s A=%h B=%h got Q=%h R=%h dz=%b required Q=%h R=%h dz=%b",
                         name, a, b, Q, R, div_zero, e.q, e.r, e.dz);
            end
            if (lat != (e.dz ? 1 : W)) begin
                miscompares++;
                $display("FAIL %s_latency got %0d required %0d", name, lat, e.dz ? 1 : W);
            end
        end
    endtask

    task automatic test_basic();
        run_and_check("basic_100_7", 32'd100, 32'd7);
        vectors++;
        if (Q !== 32'd14 || R !== 32'd2) begin
            miscompares++;
            $display("FAIL basic_const got Q=%0d R=%0d required 14 2", Q, R);
        end
    endtask

    task automatic test_signs();
        run_and_check("neg7_div_2", -32'sd7, 32'd2);
        vectors++;
        if (Q !== -32'sd3 || R !== -32'sd1) begin
            miscompares++;
            $display("FAIL neg7_const got Q=%h R=%h required fffffffd ffffffff", Q, R);
        end
        run_and_check("7_div_neg2", 32'd7, -32'sd2);
        vectors++;
        if (Q !== -32'sd3 || R !== 32'd1) begin
            miscompares++;
            $display("FAIL 7neg2_const got Q=%h R=%h required fffffffd 00000001", Q, R);
        end
    endtask

    task automatic test_div_zero();
        run_and_check("5_div_0", 32'd5, 32'd0);
        run_and_check("neg5_div_0", -32'sd5, 32'd0);
        vectors++;
        if (Q !== '0 || R !== '0 || div_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL div_zero_const got Q=%h R=%h dz=%b required 0 0 1", Q, R, div_zero);
        end
    endtask

    task automatic test_overflow();
        run_and_check("min_div_neg1", 32'h8000_0000, 32'hFFFF_FFFF);
        vectors++;
        if (Q !== 32'h8000_0000 || R !== '0) begin
            miscompares++;
            $display("FAIL overflow_const got Q=%h R=%h required 80000000 0", Q, R);
        end
    endtask

    task automatic test_unsigned();
        exp_t        e;
        logic [W-1:0] a, b;
        int          n;
        for (int i = 0; i < 40; i++) begin
            a = (i == 0) ? 32'hFFFF_FFFF : W'($urandom);
            b = (i == 0) ? 32'd2 : ((i % 7 == 3) ? 32'd0 : W'($urandom_range(1, 1000)));
            @(negedge clk);
            n = 0;
            while (!u_in_ready && n < 200) begin @(negedge clk); n++; end
            u_A = a; u_B = b; u_in_valid = 1'b1;
            @(negedge clk);
            u_in_valid = 1'b0;
            sbu_q.push_back(model(a, b, 1'b0));
            n = 0;
            while (!u_out_valid && n < 100) begin @(negedge clk); n++; end
            e = sbu_q.pop_front();
            vectors++;
            if (u_out_valid !== 1'b1 || u_Q !== e.q || u_R !== e.r || u_div_zero !== e.dz) begin
                miscompares++;
                $display("FAIL unsigned A=%h B=%h got ov=%b Q=%h R=%h dz=%b required Q=%h R=%h dz=%b",
                         a, b, u_out_valid, u_Q, u_R, u_div_zero, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_backpressure();
        int   lat; bit ok; exp_t e; int n;
        out_ready = 1'b0;
        send(32'd1000, 32'd3);
        wait_result(lat, ok);
        if (!ok) begin out_ready = 1'b1; return; end
        e = sb_q.pop_front();
        A = 32'd77; B = 32'd5; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (Q !== e.q || R !== e.r || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold cyc%0d Q=%h R=%h ov=%b rdy=%b required %h %h 1 0",
                         i, Q, R, out_valid, in_ready, e.q, e.r);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_release ov=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        last_acc = cyc;
        sb_q.push_back(model(32'd77, 32'd5, 1'b1));
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        e = sb_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || Q !== 32'd15 || R !== 32'd2 || (cyc - last_acc) != W) begin
            miscompares++;
            $display("FAIL held_request ov=%b Q=%0d R=%0d lat=%0d required 1 15 2 %0d",
                     out_valid, Q, R, cyc - last_acc, W);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit ok; int a0;
        run_and_check("b2b_first", 32'd123, 32'd10);
        a0 = last_acc;
        send(32'd55, 32'd6);
        vectors++;
        if (last_acc - a0 != W + 2) begin
            miscompares++;
            $display("FAIL issue_interval_nonzero got %0d required %0d", last_acc - a0, W + 2);
        end
        wait_result(lat, ok);
        if (ok) void'(sb_q.pop_front());
        send(32'd9, 32'd0);
        a0 = last_acc;
        wait_result(lat, ok);
        if (ok) void'(sb_q.pop_front());
        send(32'd9, 32'd3);
        vectors++;
        if (last_acc - a0 != 3) begin
            miscompares++;
            $display("FAIL issue_interval_zero got %0d required 3", last_acc - a0);
        end
        wait_result(lat, ok);
        if (ok) void'(sb_q.pop_front());
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        send(32'd100, 32'd7);
        void'(sb_q.pop_back());
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || Q !== '0 || R !== '0 || div_zero !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid ov=%b Q=%h R=%h dz=%b rdy=%b required 0 0 0 0 0",
                     out_valid, Q, R, div_zero, in_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_after stray_ov=%b rdy=%b required 0 1", seen, in_ready);
        end
        run_and_check("after_reset_9_4", 32'd9, 32'd4);
        vectors++;
        if (Q !== 32'd2 || R !== 32'd1) begin
            miscompares++;
            $display("FAIL after_reset_const got Q=%0d R=%0d required 2 1", Q, R);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int           mode;
        for (int i = 0; i < 1000; i++) begin
            mode = $urandom_range(0, 7);
            a    = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : W'($urandom);
            case (mode)
                0:       b = '0;
                1:       b = W'($urandom_range(1, 20));
                2:       b = 32'hFFFF_FFFF;
                3:       b = -W'($urandom_range(1, 300));
                default: b = W'($urandom);
            endcase
            if (mode == 4) a = W'($urandom_range(0, 5));
            run_and_check("random", a, b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_unsigned();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
